// File: rtl/mru_token_decoder.sv
// ---------------------------------------------------------------------------
// mru_token_decoder
//
// Receive-side decoder for an MRU-compressed token stream. Each token is a
// literal data word or a reference to one slot of a DEPTH-entry table of
// distinct recently-used values. The decoder rebuilds the data stream and
// keeps its table in lock-step with the transmit-side tracker.
//
// Optional feature macro: MRU_DEC_STATS_EN
//   defined     -> saturating 16-bit hit/literal counters are built
//   not defined -> hit_cnt_out / lit_cnt_out are tied to zero
//
// Ports
//   clk_in         clock, all state on rising edge
//   reset_n_in     asynchronous active-low reset
//   flush_in       synchronous table clear; blocks token accept that cycle
//   tok_valid_in   token present
//   tok_ready_out  token accepted when tok_valid_in & tok_ready_out
//   tok_is_ref_in  1 = reference token, 0 = literal token
//   tok_idx_in     referenced slot (0 = most recent)
//   tok_data_in    literal value
//   out_data       reconstructed word (registered)
//   out_valid      out_data valid
//   out_ready_in   sink accepts when out_valid & out_ready_in
//   err_out        sticky: reference to an invalid slot was received
//   hit_cnt_out    accepted valid references (stats build only)
//   lit_cnt_out    accepted literals (stats build only)
// ---------------------------------------------------------------------------
module mru_token_decoder #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_in,
  input  logic              reset_n_in,
  input  logic              flush_in,
  input  logic              tok_valid_in,
  output logic              tok_ready_out,
  input  logic              tok_is_ref_in,
  input  logic [IDX_W-1:0]  tok_idx_in,
  input  logic [DATA_W-1:0] tok_data_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready_in,
  output logic              err_out,
  output logic [15:0]       hit_cnt_out,
  output logic [15:0]       lit_cnt_out
);

  // Table storage: index 0 is the most recently used entry.
  logic [DATA_W-1:0] val_q [DEPTH];
  logic [DATA_W-1:0] val_d [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [DEPTH-1:0]  vld_d;

  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] out_data_d;
  logic              out_valid_q;
  logic              out_valid_d;
  logic              err_q;
  logic              err_d;

  logic              accept;
  logic              lit_hit;
  logic [IDX_W-1:0]  lit_idx;
  logic              ref_ok;
  logic [DATA_W-1:0] ref_val;
  logic [IDX_W-1:0]  mtf_idx;
  logic              do_mtf;
  logic              do_shift;
  logic              load_out;
  logic [DATA_W-1:0] word;

  // Output slot is free when empty or being drained this cycle; a flush
  // cycle never accepts so the table update and clear cannot collide.
  assign tok_ready_out = ~flush_in & (~out_valid_q | out_ready_in);
  assign accept        = tok_valid_in & tok_ready_out;

  // Literal lookup. Valid entries are distinct, so at most one can match.
  always_comb begin
    lit_hit = 1'b0;
    lit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (val_q[i] == tok_data_in)) begin
        lit_hit = 1'b1;
        lit_idx = IDX_W'(i);
      end
    end
  end

  // Reference lookup by compare rather than direct index so that an index
  // beyond DEPTH (non power-of-two tables) reads as an invalid slot.
  always_comb begin
    ref_ok  = 1'b0;
    ref_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tok_idx_in == IDX_W'(i)) begin
        ref_ok  = vld_q[i];
        ref_val = val_q[i];
      end
    end
  end

  assign mtf_idx  = tok_is_ref_in ? tok_idx_in : lit_idx;
  assign do_mtf   = accept & (tok_is_ref_in ? ref_ok : lit_hit);
  assign do_shift = accept & ~tok_is_ref_in & ~lit_hit;
  assign load_out = accept & (~tok_is_ref_in | ref_ok);
  assign word     = tok_is_ref_in ? ref_val : tok_data_in;

  // Table next state.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      val_d[i] = val_q[i];
    end
    vld_d = vld_q;

    if (flush_in) begin
      vld_d = '0;
    end else if (do_mtf) begin
      // Move-to-front: entries above the hit slide down one, valid bits
      // stay put (all slots 0..k are valid by contiguity).
      for (int i = 1; i < DEPTH; i++) begin
        if (i <= int'(mtf_idx)) begin
          val_d[i] = val_q[i-1];
        end
      end
      val_d[0] = word;
    end else if (do_shift) begin
      // Miss: whole table shifts with its valid bits, oldest falls off.
      for (int i = 1; i < DEPTH; i++) begin
        val_d[i] = val_q[i-1];
        vld_d[i] = vld_q[i-1];
      end
      val_d[0] = word;
      vld_d[0] = 1'b1;
    end
  end

  // Output register and sticky error.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (load_out) begin
      out_data_d  = word;
      out_valid_d = 1'b1;
    end else if (out_ready_in) begin
      out_valid_d = 1'b0;
    end
    err_d = err_q | (accept & tok_is_ref_in & ~ref_ok);
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        val_q[i] <= '0;
      end
      vld_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        val_q[i] <= val_d[i];
      end
      vld_q       <= vld_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign err_out   = err_q;

`ifdef MRU_DEC_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] hit_cnt_d;
  logic [15:0] lit_cnt_q;
  logic [15:0] lit_cnt_d;

  // Saturating counters; only reset clears them.
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    lit_cnt_d = lit_cnt_q;
    if (accept && tok_is_ref_in && ref_ok && (hit_cnt_q != 16'hFFFF)) begin
      hit_cnt_d = hit_cnt_q + 16'd1;
    end
    if (accept && !tok_is_ref_in && (lit_cnt_q != 16'hFFFF)) begin
      lit_cnt_d = lit_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      hit_cnt_q <= '0;
      lit_cnt_q <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      lit_cnt_q <= lit_cnt_d;
    end
  end

  assign hit_cnt_out = hit_cnt_q;
  assign lit_cnt_out = lit_cnt_q;
`else
  assign hit_cnt_out = 16'h0000;
  assign lit_cnt_out = 16'h0000;
`endif

endmodule

// File: doc/mru_token_decoder.md
# mru_token_decoder

Receive-side counterpart of the unique-value history tracker. It consumes a token stream where each token is either a literal data word or a reference to a slot of a 4-entry most-recently-used table of distinct values. It rebuilds the original data stream and keeps its own MRU table in lock-step with the transmit-side tracker. It sits between the link deserializer and the downstream data sink, with valid/ready on both sides.

## Interface
- DATA_W, 8, data word width
- DEPTH, 4, MRU table entries; IDX_W = $clog2(DEPTH)

- clk_in  input  1  clock, all state on rising edge
- reset_n_in  input  1  asynchronous, active-low reset
- flush_in  input  1  synchronous table clear (all entries invalid)
- tok_valid_in  input  1  token present
- tok_ready_out  output  1  token accepted when tok_valid_in & tok_ready_out
- tok_is_ref_in  input  1  1 = reference token, 0 = literal token
- tok_idx_in  input  IDX_W  referenced slot (0 = most recent)
- tok_data_in  input  DATA_W  literal value
- out_data  output  DATA_W  reconstructed word
- out_valid  output  1  out_data valid
- out_ready_in  input  1  sink accepts when out_valid & out_ready_in
- err_out  output  1  sticky: reference to an invalid slot was received
- hit_cnt_out  output  16  reference tokens decoded (see Configuration)
- lit_cnt_out  output  16  literal tokens decoded (see Configuration)

## Operation
- Table: entries e[0..DEPTH-1], each {value, valid}. e[0] is the most recent. Valid entries always hold distinct values, and they are contiguous from e[0].
- tok_ready_out = ~flush_in & (~out_valid | out_ready_in).
- Accepted literal L:
  - If L matches valid e[k]: e[1..k] <= e[0..k-1] and e[0] <= L (move-to-front). Valid bits are unchanged.
  - Otherwise, a miss: all entries shift down one slot with their valid bits, e[0] <= {L,1}, and e[DEPTH-1] is discarded.
  - Output word = L.
- Accepted reference k with e[k].valid: output word = e[k].value, followed by the same move-to-front as a literal hit.
- Accepted reference k with e[k] invalid:
  - Token is consumed; no output word and no table change.
  - err_out set; it stays set until reset.
- flush_in high: all valid bits cleared at the next edge. No token is accepted that cycle. The output register and err_out are unaffected.
- Output register: loaded on token accept (except the error case). out_valid is cleared when the word is taken and no new word is loaded.

## Timing
- Reset values: out_data = 0, out_valid = 0, err_out = 0, counters = 0, all table valid bits = 0, table values = 0.
- Latency: token accepted at edge N gives out_valid = 1 with the decoded data after edge N.
- Throughput: one token per cycle while out_ready_in = 1.
- Back-to-back: a reference in cycle N+1 sees the table as updated by the token of cycle N.
- Stall: out_valid = 1 and out_ready_in = 0 hold out_data stable and drive tok_ready_out = 0.
- Sink take and token accept in the same cycle: the new word replaces the old one with out_valid staying 1.
- Reset asserted mid-stream: everything returns to reset values immediately (asynchronous). Deassertion is synchronized externally.
- tok_* inputs are ignored when tok_valid_in = 0. tok_data_in is ignored for references; tok_idx_in is ignored for literals.

## Configuration
- MRU_DEC_STATS_EN defined:
  - hit_cnt_out counts accepted valid references.
  - lit_cnt_out counts accepted literals.
  - Both are saturating at 16'hFFFF and cleared only by reset.
- Not defined: counter logic is not compiled; hit_cnt_out and lit_cnt_out are tied to 0.

## Test plan
- Literals 1,2,3,4,5 with out_ready_in = 1 -> outputs 1,2,3,4,5 one cycle after each accept; final table e[0..3] = 5,4,3,2, all valid.
- Literals 1,2 then ref 1, ref 1 -> outputs 1,2,1,2; table after the last token = {2,1}; with MRU_DEC_STATS_EN, hit_cnt_out = 2 and lit_cnt_out = 2.
- Literals 1,2,3 then literal 2 (duplicate) -> output 2; table = 2,3,1 with 3 entries valid, e[3] still invalid.
- After reset, ref 0 -> no out_valid; err_out = 1 and stays 1. Then literal 7 -> output 7, err_out still 1.
- Literal stream with out_ready_in held low 3 cycles after the first word -> tok_ready_out = 0 and out_data stable for those cycles; no token lost or duplicated.
- Literals 1,2, pulse flush_in with tok_valid_in = 1, then ref 0 -> no accept during the flush cycle; afterwards ref 0 sets err_out.
